// File: rtl/fpga_exit_blinker.sv
// Captures the MCU exit status and shows it on board LEDs: pass/fail/done
// lamps plus a code LED that repeatedly blinks the low bits of the exit value.
module fpga_exit_blinker #(
  parameter int unsigned BLINK_ON_CYCLES  = 25_000_000,
  parameter int unsigned BLINK_OFF_CYCLES = 25_000_000,
  parameter int unsigned GAP_CYCLES       = 100_000_000,
  parameter int unsigned CODE_BITS        = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        exit_valid_i,
  input  logic [31:0] exit_value_i,
  output logic        done_led_o,
  output logic        pass_led_o,
  output logic        fail_led_o,
  output logic        code_led_o,
  output logic [31:0] code_o
);

  localparam int unsigned MAX_A   = (BLINK_ON_CYCLES > BLINK_OFF_CYCLES) ?
                                    BLINK_ON_CYCLES : BLINK_OFF_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
  // Timer only ever reaches MAX_CYC-1, so $clog2 bits suffice; keep at least one bit.
  localparam int unsigned TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int unsigned CW      = CODE_BITS;

  localparam logic [TW-1:0] ON_LAST  = TW'(BLINK_ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(BLINK_OFF_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PASS   = 3'd1;
  localparam logic [2:0] S_STEADY = 3'd2;
  localparam logic [2:0] S_ON     = 3'd3;
  localparam logic [2:0] S_OFF    = 3'd4;
  localparam logic [2:0] S_GAP    = 3'd5;

  logic [2:0]    state_q, state_d;
  logic          valid_q, valid_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] bcnt_q, bcnt_d;
  logic [CW-1:0] n_q, n_d;
  logic [31:0]   code_q, code_d;
  logic          done_led_q, done_led_d;
  logic          pass_led_q, pass_led_d;
  logic          fail_led_q, fail_led_d;
  logic          code_led_q, code_led_d;
  logic          capture;

  // Next-state logic; a capture overrides any timer expiry on the same edge.
  always_comb begin
    state_d = state_q;
    valid_d = exit_valid_i;
    timer_d = timer_q;
    bcnt_d  = bcnt_q;
    n_d     = n_q;
    code_d  = code_q;
    capture = exit_valid_i && !valid_q;

    if (capture) begin
      code_d  = exit_value_i;
      n_d     = exit_value_i[CW-1:0];
      timer_d = '0;
      if (exit_value_i == 32'd0) begin
        state_d = S_PASS;
      end else if (exit_value_i[CW-1:0] == '0) begin
        state_d = S_STEADY;
      end else begin
        state_d = S_ON;
        bcnt_d  = CW'(1);
      end
    end else begin
      case (state_q)
        S_ON: begin
          if (timer_q == ON_LAST) begin
            state_d = S_OFF;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        S_OFF: begin
          if (timer_q == OFF_LAST) begin
            timer_d = '0;
            if (bcnt_q < n_q) begin
              state_d = S_ON;
              bcnt_d  = bcnt_q + CW'(1);
            end else begin
              state_d = S_GAP;
            end
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        S_GAP: begin
          if (timer_q == GAP_LAST) begin
            state_d = S_ON;
            timer_d = '0;
            bcnt_d  = CW'(1);
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        S_IDLE, S_PASS, S_STEADY: begin
          state_d = state_q;
        end
        default: begin
          state_d = S_IDLE;
          timer_d = '0;
        end
      endcase
    end

    // LEDs are decoded from the next state so they line up with it after the edge.
    done_led_d = (state_d != S_IDLE);
    pass_led_d = (state_d == S_PASS);
    fail_led_d = (state_d == S_STEADY) || (state_d == S_ON) ||
                 (state_d == S_OFF)    || (state_d == S_GAP);
    code_led_d = (state_d == S_ON) || (state_d == S_STEADY);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      valid_q    <= 1'b0;
      timer_q    <= '0;
      bcnt_q     <= '0;
      n_q        <= '0;
      code_q     <= '0;
      done_led_q <= 1'b0;
      pass_led_q <= 1'b0;
      fail_led_q <= 1'b0;
      code_led_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      timer_q    <= timer_d;
      bcnt_q     <= bcnt_d;
      n_q        <= n_d;
      code_q     <= code_d;
      done_led_q <= done_led_d;
      pass_led_q <= pass_led_d;
      fail_led_q <= fail_led_d;
      code_led_q <= code_led_d;
    end
  end

  assign done_led_o = done_led_q;
  assign pass_led_o = pass_led_q;
  assign fail_led_o = fail_led_q;
  assign code_led_o = code_led_q;
  assign code_o     = code_q;

endmodule

// File: doc/fpga_exit_blinker.md
# fpga_exit_blinker

Downstream consumer of the `x_heep_system` end-of-program status on the FPGA top level. It captures `exit_valid`/`exit_value` when the program finishes and shows the result on board LEDs, so a run can be judged without JTAG or UART:
- a pass LED when the exit value is zero;
- a fail LED when it is non-zero;
- a code LED that repeatedly blinks the low bits of the exit value.

It runs in the same clock domain as the MCU (`clk_gen`).

## Interface
Parameters:
- `BLINK_ON_CYCLES`, default 25_000_000: cycles the code LED stays on per blink (≥1).
- `BLINK_OFF_CYCLES`, default 25_000_000: cycles off between blinks within one burst (≥1).
- `GAP_CYCLES`, default 100_000_000: cycles off between bursts (≥1).
- `CODE_BITS`, default 4: number of exit-value LSBs shown as a blink count (1..8).

Ports:
- `clk_i` in, 1: system clock.
- `rst_ni` in, 1: reset. One clock; reset is asynchronous and active-low.
- `exit_valid_i` in, 1: level from the MCU, high once the program has exited.
- `exit_value_i` in, 32: exit value; valid while `exit_valid_i`=1.
- `done_led_o` out, 1: an exit has been captured.
- `pass_led_o` out, 1: captured value == 0.
- `fail_led_o` out, 1: captured value != 0.
- `code_led_o` out, 1: blink-code output.
- `code_o` out, 32: registered copy of the captured exit value, for debug/ILA.

## Operation
- Edge detect: register `valid_q` <= `exit_valid_i`. A capture event is `exit_valid_i`=1 && `valid_q`=0.
- On a capture event:
  - latch `code_o` <= `exit_value_i`;
  - latch `n` <= `exit_value_i[CODE_BITS-1:0]`.
- Falling edges of `exit_valid_i` are ignored. All outputs hold until the next capture event or reset.
- A capture event in any state aborts the current sequence and restarts from the new value. This covers a re-run after a core-only reset.
- FSM states: IDLE, PASS, STEADY, ON, OFF, GAP.
  - IDLE → PASS: capture with value == 0.
  - IDLE → STEADY: capture with value != 0 and `n` == 0.
  - IDLE → ON: capture with `n` != 0. Blink counter `bcnt` <= 1, timer <= 0.
  - PASS, STEADY: terminal until the next capture.
  - ON → OFF: after `BLINK_ON_CYCLES` cycles in ON.
  - OFF → ON: after `BLINK_OFF_CYCLES` cycles, if `bcnt` < `n`; `bcnt`++.
  - OFF → GAP: after `BLINK_OFF_CYCLES` cycles, if `bcnt` == `n`.
  - GAP → ON: after `GAP_CYCLES` cycles; `bcnt` <= 1.
- Outputs (all registered):
  - `code_led_o` = 1 in ON and STEADY, 0 elsewhere.
  - `done_led_o` = 1 in every state except IDLE.
  - `pass_led_o` = 1 in PASS only.
  - `fail_led_o` = 1 in STEADY/ON/OFF/GAP.
- Timer width is `$clog2` of the largest cycle parameter. It resets to 0 on every state transition and never wraps inside a state.
- `bcnt` width is `CODE_BITS`.
- Resulting blink sequence: `n` is compared before increment, so at most 2^`CODE_BITS`−1 blinks per burst.

## Timing
- Reset values:
  - state IDLE, `valid_q` 0, timer 0, `bcnt` 0;
  - all LED outputs 0;
  - `code_o` 0.
- Capture latency: `exit_valid_i` sampled high at clock edge k → new state, `code_o` and LEDs valid after edge k.
- State durations are exact: ON = `BLINK_ON_CYCLES` cycles, OFF = `BLINK_OFF_CYCLES` cycles, GAP = `GAP_CYCLES` cycles.
- Burst period = `n`·(ON+OFF) + GAP.
- Capture on the same edge as an internal timer expiry: the capture wins.
- If `exit_valid_i` is already high when `rst_ni` deasserts, capture occurs on the first clock edge after reset release.
- Reset asserted mid-sequence: all outputs drop to reset values immediately (asynchronously).

## Test plan
Parameters for all scenarios: ON=4, OFF=3, GAP=10, CODE_BITS=4.
- Reset with `exit_valid_i`=0 for 50 cycles → all LEDs 0, `code_o`=0.
- Raise `exit_valid_i` with value 0 → next edge: `done_led_o`=1, `pass_led_o`=1, `fail_led_o`=0, `code_led_o`=0; stable for 200 cycles.
- Value 0x0000_0003 → `fail_led_o`=1; `code_led_o` pattern 1111 000 1111 000 1111 000 then 10×0, repeating; exactly 3 rising edges per 31-cycle period.
- Value 0x0000_0020 (`n`=0, nonzero) → `fail_led_o`=1, `code_led_o` steady 1, `code_o`=0x20.
- Mid-burst with value 5: drop `exit_valid_i`, outputs unchanged; raise it with value 0 → next edge `pass_led_o`=1, `code_led_o`=0, `code_o`=0.
- Assert `rst_ni` during an ON phase → all outputs 0 without waiting for a clock; after release with `exit_valid_i` held high at value 1 → capture on the first edge, one blink per 17-cycle period.
